// File: rtl/ppu_vbuf_pkg.sv
// Shared video-buffer definitions for the PPU write side and the LCD scan-out side.
// Both sides build RAM addresses with vbuf_addr() so the page/line/pixel layout stays identical.
package ppu_vbuf_pkg;

  localparam int   VBUF_ADDR_W  = 17;
  localparam int   VBUF_DATA_W  = 8;
  localparam int   H_PIX        = 256;
  localparam int   V_LINES      = 240;
  localparam logic SYNC_RST_VAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } vbuf_state_e;

  function automatic logic [VBUF_ADDR_W-1:0] vbuf_addr(input logic       page,
                                                       input logic [7:0] y,
                                                       input logic [7:0] x);
    return {page, y, x};
  endfunction

endpackage

// File: rtl/ppu_vbuf_wr_if.sv
// Pixel-stream, video-RAM write and frame-status signals between PPU control and ppu_vbuf_wr.
// master = PPU/control side, slave = ppu_vbuf_wr.
interface ppu_vbuf_wr_if;

  logic                                i_frame_start;
  logic                                i_pix_vld;
  logic                                o_pix_rdy;
  logic [ppu_vbuf_pkg::VBUF_DATA_W-1:0] i_pix_hsv;
  logic                                i_lcd_page;
  logic                                o_vbuf_we;
  logic [ppu_vbuf_pkg::VBUF_ADDR_W-1:0] o_vbuf_addr;
  logic [ppu_vbuf_pkg::VBUF_DATA_W-1:0] o_vbuf_wdata;
  logic                                o_frame_done;
  logic                                o_frame_err;
  logic                                o_wr_page;

  modport master (
    output i_frame_start, i_pix_vld, i_pix_hsv, i_lcd_page,
    input  o_pix_rdy, o_vbuf_we, o_vbuf_addr, o_vbuf_wdata,
           o_frame_done, o_frame_err, o_wr_page
  );

  modport slave (
    input  i_frame_start, i_pix_vld, i_pix_hsv, i_lcd_page,
    output o_pix_rdy, o_vbuf_we, o_vbuf_addr, o_vbuf_wdata,
           o_frame_done, o_frame_err, o_wr_page
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow cross-domain flag, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: flops always use non-blocking assignments so every register samples the pre-edge value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ppu_vbuf_wr.sv
// Writes the PPU raster pixel stream into the video-RAM page the LCD is not reading,
// and flags completed and aborted frames to PPU control.
module ppu_vbuf_wr #(
  parameter int   H_PIX        = ppu_vbuf_pkg::H_PIX,
  parameter int   V_LINES      = ppu_vbuf_pkg::V_LINES,
  parameter logic SYNC_RST_VAL = ppu_vbuf_pkg::SYNC_RST_VAL
) (
  input logic          i_ppu_clk,
  input logic          i_ppu_rst,
  ppu_vbuf_wr_if.slave bus
);
  import ppu_vbuf_pkg::*;

  localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  logic lcd_pg_s;

  sync_2ff #(
    .RST_VAL(SYNC_RST_VAL)
  ) u_page_sync (
    .clk_i(i_ppu_clk),
    .rst_i(i_ppu_rst),
    .d_i  (bus.i_lcd_page),
    .q_o  (lcd_pg_s)
  );

  vbuf_state_e            state_q;
  logic [7:0]             x_q, x_d;
  logic [7:0]             y_q, y_d;
  logic                   wr_page_q;
  logic                   pix_rdy_q;
  logic                   we_q;
  logic [VBUF_ADDR_W-1:0] addr_q;
  logic [VBUF_DATA_W-1:0] wdata_q;
  logic                   frame_done_q;
  logic                   frame_err_q;

  logic accept;
  logic last_pix;
  logic restart;

  assign accept   = bus.i_pix_vld & pix_rdy_q;
  assign last_pix = accept && (x_q == X_LAST) && (y_q == Y_LAST);
  assign restart  = bus.i_frame_start && (state_q != ST_IDLE);

  // NOTE: defaults first, so no path through this block can leave x_d/y_d unassigned (no latch).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (restart) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      wr_page_q    <= 1'b0;
      pix_rdy_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      we_q         <= accept;
      frame_done_q <= last_pix;
      // A frame start that coincides with the last pixel is a clean hand-over, not an abort.
      frame_err_q  <= (state_q == ST_WRITE) && bus.i_frame_start && !last_pix;
      if (accept) begin
        addr_q  <= vbuf_addr(wr_page_q, y_q, x_q);
        wdata_q <= bus.i_pix_hsv;
      end

      unique case (state_q)
        ST_IDLE: begin
          state_q   <= ST_WAIT;
          pix_rdy_q <= 1'b0;
        end
        ST_WAIT, ST_DONE: begin
          if (bus.i_frame_start) begin
            state_q   <= ST_WRITE;
            wr_page_q <= ~lcd_pg_s;
            pix_rdy_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (bus.i_frame_start) begin
            wr_page_q <= ~lcd_pg_s;
          end else if (last_pix) begin
            state_q   <= ST_DONE;
            pix_rdy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pix_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pix_rdy    = pix_rdy_q;
  assign bus.o_vbuf_we    = we_q;
  assign bus.o_vbuf_addr  = addr_q;
  assign bus.o_vbuf_wdata = wdata_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_frame_err  = frame_err_q;
  assign bus.o_wr_page    = wr_page_q;

  // x and y are packed into 8-bit address fields.
  a_geometry: assert property (@(posedge i_ppu_clk)
    (H_PIX > 0) && (H_PIX <= 256) && (V_LINES > 0) && (V_LINES <= 256));

endmodule

// File: doc/ppu_vbuf_wr.md
Name: ppu_vbuf_wr

Overview:
- Upstream neighbour of the LCD scan-out stage.
- Accepts the PPU's raster pixel stream (7-bit HSV colour plus flag bit, 256x240, raster order) on a valid/ready handshake.
- Writes it into the double-buffered video RAM using the shared 17-bit address {page, y[7:0], x[7:0]}.
- Always writes the page opposite to the one the LCD side is currently reading, and reports frame completion and framing errors to PPU control.

Parameters:
- H_PIX, 256, pixels per line; x counter wraps at H_PIX-1.
- V_LINES, 240, visible lines per frame; frame completes after pixel (H_PIX-1, V_LINES-1).
- SYNC_RST_VAL, 1, reset value of the synchronised LCD page (LCD scan-out starts on page 1).

Ports:
- i_ppu_clk  input  1  PPU clock; all logic on rising edge.
- i_ppu_rst  input  1  synchronous, active-high reset.
- i_frame_start  input  1  one-cycle pulse at start of PPU visible frame.
- i_pix_vld  input  1  pixel valid.
- o_pix_rdy  output  1  block can accept a pixel this cycle.
- i_pix_hsv  input  8  pixel data, written verbatim; bit 7 is a pass-through flag.
- i_lcd_page  input  1  page the LCD is reading; asynchronous (LCD clock domain).
- o_vbuf_we  output  1  video RAM write enable.
- o_vbuf_addr  output  17  {page, y, x}.
- o_vbuf_wdata  output  8  write data.
- o_frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
- o_frame_err  output  1  one-cycle pulse when a frame is aborted by an early i_frame_start.
- o_wr_page  output  1  page currently being written.

Behaviour:
- Reset values:
  - State IDLE; x = y = 0.
  - o_wr_page = 0, o_pix_rdy = 0, o_vbuf_we = 0, o_vbuf_addr = 0, o_vbuf_wdata = 0, o_frame_done = 0, o_frame_err = 0.
  - Synchroniser flops = SYNC_RST_VAL.
- Page synchroniser:
  - i_lcd_page passes through 2 flops into lcd_pg_s.
  - Only lcd_pg_s is used.
- States:
  - IDLE: o_pix_rdy = 0. Leaves one cycle after reset deasserts, to WAIT.
  - WAIT: o_pix_rdy = 0. On i_frame_start: wr_page <= ~lcd_pg_s, x = y = 0, go to WRITE.
  - WRITE: o_pix_rdy = 1. A pixel is accepted when i_pix_vld & o_pix_rdy.
    - Next cycle after acceptance: o_vbuf_we = 1, o_vbuf_addr = {wr_page, y, x} at acceptance, o_vbuf_wdata = i_pix_hsv. Write latency is exactly 1 cycle.
    - Then x++. If x == H_PIX-1: x = 0, y++.
    - Accepting pixel (H_PIX-1, V_LINES-1) moves the state to DONE. o_frame_done pulses in the same cycle as that pixel's o_vbuf_we.
  - DONE: o_pix_rdy = 0. On i_frame_start: recapture page as in WAIT, go to WRITE.
- o_vbuf_we is low in every cycle without an acceptance in the previous cycle. Address and data hold their last values when we = 0.
- i_frame_start while in WRITE (short frame):
  - o_frame_err pulses next cycle.
  - x = y = 0 and the page is recaptured; state stays WRITE.
  - A pixel accepted in that same cycle is still written to the old address.
- i_frame_start and the last pixel in the same cycle:
  - The last pixel is written and o_frame_done pulses.
  - The new frame starts (WRITE, recapture); no o_frame_err.
- i_frame_start during IDLE is ignored.
- o_wr_page changes only at recapture. A change of lcd_pg_s mid-frame does not change the page being written.
- i_pix_vld in WAIT, DONE or IDLE: not accepted; no write, no count.
- Reset mid-frame: all state is reset in the next cycle. A write already registered in the reset cycle is suppressed (o_vbuf_we = 0).
- Width rules: x and y are 8 bits. V_LINES ≤ 256 and H_PIX ≤ 256, checked by a simulation assertion.

Decomposition:
- Shared package ppu_vbuf_pkg:
  - VBUF_ADDR_W = 17, VBUF_DATA_W = 8, H_PIX, V_LINES.
  - State encoding IDLE/WAIT/WRITE/DONE.
  - Address-packing function {page, y, x}; the LCD scan-out stage uses the same function.
- One sub-module: sync_2ff (1-bit, parameterised reset value), reusable for other cross-domain flags.

Test Plan:
- Reset, lcd_page = 1, frame_start, then 61440 back-to-back valid pixels with data = x ^ y -> writes to page 0; first addr 0x00000, last addr 0x0EFFF; o_frame_done pulses exactly once with the final write; o_pix_rdy = 0 afterwards.
- Valid toggled every other cycle with random gaps -> exactly 61440 writes; addresses strictly raster-ordered; no write in gap+1 cycles.
- lcd_page flipped to 0 mid-frame, then next frame_start -> current frame stays on page 0; next frame writes page 1 (first addr 0x10000); switch occurs ≥ 2 cycles after the flip.
- frame_start after 1000 pixels -> o_frame_err pulse; next accepted pixel writes {page, 0, 0}; no o_frame_done for the aborted frame.
- frame_start coincident with the last pixel -> write to {p, 239, 255}, o_frame_done = 1, o_frame_err = 0, next pixel goes to addr {~lcd_pg_s, 0, 0}.
- Reset asserted mid-frame during accepted pixels -> o_vbuf_we = 0 the next cycle; all outputs at reset values; pixels ignored until the next frame_start.
